score_display: RTL and testbench

Score stage of the snake game's video path. Keeps the running score as a 4-digit BCD counter and renders it as glyphs fetched from the digit-sprite block RAM (the initialized single-port SRAM loaded from `score.mem`). The block drives that RAM's address/enable, consumes its registered read data, and returns a pixel-aligned colour and hit flag to the VGA pixel mixer.

---
 rtl/score_display.sv | 192 +++++++++++++++++++
 tb/tb_score_display.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: score stage of the snake game's video path.
//
// Keeps a saturating 4-digit BCD score and renders it as four glyphs fetched
// from the digit-sprite RAM (glyphs 0-9 stored back to back, DIGIT_W*DIGIT_H
// pixels each). A copy of the score is latched at frame_start so a frame never
// shows a half-updated number. Pixel path latency is 3 clocks, one pixel per
// clock:
//   edge 1: region decode -> sram_addr_o / sram_en_o
//   edge 2: RAM registers sram_data_i, hit flag advances
//   edge 3: pix_hit_o / pix_color_o
//
// Ports:
//   clk_i          pixel clock
//   reset_i        synchronous, active-high reset
//   score_inc_i    one-cycle pulse, score += 1 (saturates at 9999)
//   score_clr_i    one-cycle pulse, score = 0 (wins over score_inc_i)
//   frame_start_i  one-cycle pulse at vsync, latches the display copy
//   pix_x_i        current pixel column
//   pix_y_i        current pixel row
//   pix_valid_i    pix_x_i/pix_y_i are in the visible area
//   sram_addr_o    registered sprite RAM address
//   sram_en_o      registered sprite RAM enable
//   sram_data_i    sprite RAM read data, registered one cycle after sram_addr_o
//   score_bcd_o    live score, [15:12] is the most significant digit
//   pix_hit_o      output pixel is an opaque score pixel
//   pix_color_o    output pixel colour, 0 when pix_hit_o is low
module score_display #(
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter int unsigned            ADDR_WIDTH  = 16,
   parameter int unsigned            DIGIT_W     = 16,
   parameter int unsigned            DIGIT_H     = 24,
   parameter int unsigned            ORIG_X      = 560,
   parameter int unsigned            ORIG_Y      = 8,
   parameter logic [DATA_WIDTH-1:0]  TRANSPARENT = '0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  score_inc_i,
   input  logic                  score_clr_i,
   input  logic                  frame_start_i,
   input  logic [9:0]            pix_x_i,
   input  logic [9:0]            pix_y_i,
   input  logic                  pix_valid_i,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic                  sram_en_o,
   input  logic [DATA_WIDTH-1:0] sram_data_i,
   output logic [15:0]           score_bcd_o,
   output logic                  pix_hit_o,
   output logic [DATA_WIDTH-1:0] pix_color_o
);

   localparam int unsigned DigShift  = $clog2(DIGIT_W);
   localparam int unsigned GlyphSize = DIGIT_W * DIGIT_H;
   localparam int unsigned FieldW    = 4 * DIGIT_W;

   // ---------------------------------------------------------------------------
   // Score counter and display copy
   // ---------------------------------------------------------------------------
   logic [15:0] score_q, score_d;
   logic [15:0] disp_q;

   // BCD +1 with carry rippling through all four digits.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      score_d = score_q;
      if (score_clr_i) begin
         score_d = 16'h0000;
      end else if (score_inc_i && (score_q != 16'h9999)) begin
         score_d = bcd_inc(score_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         score_q <= 16'h0000;
         disp_q  <= 16'h0000;
      end else begin
         score_q <= score_d;
         // Samples score_q, so a coincident increment is not yet visible.
         if (frame_start_i) begin
            disp_q <= score_q;
         end
      end
   end

   assign score_bcd_o = score_q;

   // ---------------------------------------------------------------------------
   // Stage 1: region decode, digit select, blanking, address
   // ---------------------------------------------------------------------------
   logic [31:0]           px, py, dx, dy, col;
   logic [1:0]            slot;
   logic [3:0]            digit;
   logic                  in_field;
   logic                  blank;
   logic [ADDR_WIDTH-1:0] addr_d;

   always_comb begin
      px  = 32'(pix_x_i);
      py  = 32'(pix_y_i);
      dx  = px - ORIG_X;
      dy  = py - ORIG_Y;
      col = dx & (DIGIT_W - 1);

      in_field = pix_valid_i &&
                 (px >= ORIG_X) && (px < ORIG_X + FieldW) &&
                 (py >= ORIG_Y) && (py < ORIG_Y + DIGIT_H);

      // Slot 0 is the leftmost, most-significant digit.
      slot = dx[DigShift +: 2];

      // A slot blanks when it and every more-significant digit are zero;
      // the units slot always shows.
      digit = 4'd0;
      blank = 1'b0;
      case (slot)
         2'd0: begin
            digit = disp_q[15:12];
            blank = (disp_q[15:12] == 4'd0);
         end
         2'd1: begin
            digit = disp_q[11:8];
            blank = (disp_q[15:8] == 8'd0);
         end
         2'd2: begin
            digit = disp_q[7:4];
            blank = (disp_q[15:4] == 12'd0);
         end
         default: begin
            digit = disp_q[3:0];
            blank = 1'b0;
         end
      endcase

      addr_d = ADDR_WIDTH'(32'(digit) * GlyphSize + dy * DIGIT_W + col);
   end

   // ---------------------------------------------------------------------------
   // Pipeline registers
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] sram_addr_q;
   logic                  sram_en_q;
   logic                  hit_d2_q;
   logic                  pix_hit_q;
   logic [DATA_WIDTH-1:0] pix_color_q;
   logic                  opaque;

   assign opaque = hit_d2_q && (sram_data_i != TRANSPARENT);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sram_addr_q <= '0;
         sram_en_q   <= 1'b0;
         hit_d2_q    <= 1'b0;
         pix_hit_q   <= 1'b0;
         pix_color_q <= '0;
      end else begin
         // Address holds outside the field to avoid needless RAM toggling.
         if (in_field) begin
            sram_addr_q <= addr_d;
         end
         // sram_en_q doubles as the first stage of the hit-flag pipeline.
         sram_en_q   <= in_field && !blank;
         hit_d2_q    <= sram_en_q;
         pix_hit_q   <= opaque;
         pix_color_q <= opaque ? sram_data_i : '0;
      end
   end

   assign sram_addr_o = sram_addr_q;
   assign sram_en_o   = sram_en_q;
   assign pix_hit_o   = pix_hit_q;
   assign pix_color_o = pix_color_q;

endmodule

// File: tb/tb_score_display.sv
// Directed testbench for score_display. A behavioural sprite RAM returns
// 8'hE0 for every glyph pixel except column 15, which is transparent (0).
module tb_score_display;

   localparam int OX = 560;
   localparam int OY = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        score_inc;
   logic        score_clr;
   logic        frame_start;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_valid;
   logic [15:0] sram_addr;
   logic        sram_en;
   logic [7:0]  sram_data;
   logic [15:0] score_bcd;
   logic        pix_hit;
   logic [7:0]  pix_color;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   score_display dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .score_inc_i   (score_inc),
      .score_clr_i   (score_clr),
      .frame_start_i (frame_start),
      .pix_x_i       (pix_x),
      .pix_y_i       (pix_y),
      .pix_valid_i   (pix_valid),
      .sram_addr_o   (sram_addr),
      .sram_en_o     (sram_en),
      .sram_data_i   (sram_data),
      .score_bcd_o   (score_bcd),
      .pix_hit_o     (pix_hit),
      .pix_color_o   (pix_color)
   );

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return (a[3:0] == 4'hF) ? 8'h00 : 8'hE0;
   endfunction

   // Sprite RAM model: one-cycle registered read.
   initial sram_data = 8'h00;
   always @(posedge clk) begin
      if (sram_en) sram_data <= mem_val(sram_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic inc_n(input int n);
      for (int i = 0; i < n; i++) begin
         score_inc = 1'b1;
         step();
         score_inc = 1'b0;
      end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   // Present one pixel for one clock; afterwards the stage-1 outputs reflect it.
   task automatic drive_px(input int x, input int y);
      pix_x     = 10'(x);
      pix_y     = 10'(y);
      pix_valid = 1'b1;
      step();
      pix_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (score_bcd !== 16'h0000) $display("FAIL reset_score: got %h want 0000", score_bcd); else passes++;
      checks++; if (sram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", sram_en); else passes++;
      checks++; if (sram_addr !== 16'd0) $display("FAIL reset_addr: got %0d want 0", sram_addr); else passes++;
      checks++; if (pix_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", pix_hit); else passes++;
      checks++; if (pix_color !== 8'h00) $display("FAIL reset_color: got %h want 00", pix_color); else passes++;
      reset = 1'b0;
   endtask

   task automatic test_blank_zero();
      frame();
      drive_px(OX, OY);
      checks++; if (sram_en !== 1'b0) $display("FAIL zero_slot0_en: got %b want 0", sram_en); else passes++;
      drive_px(OX + 48, OY);
      checks++; if (sram_en !== 1'b1) $display("FAIL zero_slot3_en: got %b want 1", sram_en); else passes++;
      checks++; if (sram_addr !== 16'd0) $display("FAIL zero_slot3_addr: got %0d want 0", sram_addr); else passes++;
      step();
      checks++; if (pix_hit !== 1'b0) $display("FAIL zero_hit_early: got %b want 0", pix_hit); else passes++;
      step();
      checks++; if (pix_hit !== 1'b1) $display("FAIL zero_hit_lat3: got %b want 1", pix_hit); else passes++;
      checks++; if (pix_color !== 8'hE0) $display("FAIL zero_color: got %h want e0", pix_color); else passes++;
   endtask

   task automatic test_count_1234();
      do_reset();
      inc_n(1234);
      checks++; if (score_bcd !== 16'h1234) $display("FAIL count_1234: got %h want 1234", score_bcd); else passes++;
      frame();
      drive_px(OX + 21, OY + 3);
      checks++; if (sram_addr !== 16'd821) $display("FAIL count_addr821: got %0d want 821", sram_addr); else passes++;
      checks++; if (sram_en !== 1'b1) $display("FAIL count_en: got %b want 1", sram_en); else passes++;
      step();
      step();
      checks++; if (pix_hit !== 1'b1) $display("FAIL count_hit: got %b want 1", pix_hit); else passes++;
      checks++; if (pix_color !== 8'hE0) $display("FAIL count_color: got %h want e0", pix_color); else passes++;
      drive_px(OX + 2, OY);
      checks++; if (sram_addr !== 16'd386) $display("FAIL count_slot0_addr: got %0d want 386", sram_addr); else passes++;
      checks++; if (sram_en !== 1'b1) $display("FAIL count_slot0_en: got %b want 1", sram_en); else passes++;
   endtask

   task automatic test_saturate();
      do_reset();
      inc_n(9998);
      checks++; if (score_bcd !== 16'h9998) $display("FAIL sat_9998: got %h want 9998", score_bcd); else passes++;
      inc_n(3);
      checks++; if (score_bcd !== 16'h9999) $display("FAIL sat_9999: got %h want 9999", score_bcd); else passes++;
      score_inc = 1'b1;
      score_clr = 1'b1;
      step();
      score_inc = 1'b0;
      score_clr = 1'b0;
      checks++; if (score_bcd !== 16'h0000) $display("FAIL clr_wins: got %h want 0000", score_bcd); else passes++;
   endtask

   task automatic test_display_copy();
      inc_n(6);
      drive_px(OX + 48, OY);
      checks++; if (sram_addr !== 16'd0) $display("FAIL copy_stale_addr: got %0d want 0", sram_addr); else passes++;
      // frame_start together with an increment latches the old value (6).
      score_inc   = 1'b1;
      frame_start = 1'b1;
      step();
      score_inc   = 1'b0;
      frame_start = 1'b0;
      checks++; if (score_bcd !== 16'h0007) $display("FAIL copy_score7: got %h want 0007", score_bcd); else passes++;
      drive_px(OX + 48, OY);
      checks++; if (sram_addr !== 16'd2304) $display("FAIL copy_pre_inc: got %0d want 2304", sram_addr); else passes++;
      frame();
      drive_px(OX + 48, OY);
      checks++; if (sram_addr !== 16'd2688) $display("FAIL copy_digit7: got %0d want 2688", sram_addr); else passes++;
      for (int s = 0; s < 3; s++) begin
         drive_px(OX + 16 * s + 4, OY + 1);
         checks++; if (sram_en !== 1'b0) $display("FAIL copy_blank_slot%0d: got %b want 0", s, sram_en); else passes++;
      end
   endtask

   task automatic test_transparent_edges();
      drive_px(OX + 63, OY);
      checks++; if (sram_addr !== 16'd2703) $display("FAIL edge_right_in_addr: got %0d want 2703", sram_addr); else passes++;
      checks++; if (sram_en !== 1'b1) $display("FAIL edge_right_in_en: got %b want 1", sram_en); else passes++;
      step();
      step();
      checks++; if (pix_hit !== 1'b0) $display("FAIL transp_hit: got %b want 0", pix_hit); else passes++;
      checks++; if (pix_color !== 8'h00) $display("FAIL transp_color: got %h want 00", pix_color); else passes++;
      drive_px(OX - 1, OY);
      checks++; if (sram_en !== 1'b0) $display("FAIL edge_left_out_en: got %b want 0", sram_en); else passes++;
      checks++; if (sram_addr !== 16'd2703) $display("FAIL edge_addr_hold: got %0d want 2703", sram_addr); else passes++;
      step();
      step();
      checks++; if (pix_hit !== 1'b0) $display("FAIL edge_left_hit: got %b want 0", pix_hit); else passes++;
      drive_px(OX + 64, OY);
      checks++; if (sram_en !== 1'b0) $display("FAIL edge_right_out_en: got %b want 0", sram_en); else passes++;
      drive_px(OX + 48, OY + 24);
      checks++; if (sram_en !== 1'b0) $display("FAIL edge_bottom_out_en: got %b want 0", sram_en); else passes++;
      drive_px(OX + 48, OY + 23);
      checks++; if (sram_addr !== 16'd3056) $display("FAIL edge_bottom_in_addr: got %0d want 3056", sram_addr); else passes++;
      pix_x     = 10'(OX + 48);
      pix_y     = 10'(OY);
      pix_valid = 1'b0;
      step();
      checks++; if (sram_en !== 1'b0) $display("FAIL invalid_en: got %b want 0", sram_en); else passes++;
      step();
      step();
   endtask

   task automatic test_back_to_back();
      pix_y     = 10'(OY);
      pix_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pix_x = 10'(OX + 48 + i);
         step();
         checks++; if (sram_addr !== 16'(2688 + i)) $display("FAIL b2b_addr%0d: got %0d want %0d", i, sram_addr, 2688 + i); else passes++;
      end
      step();
      step();
      checks++; if (pix_hit !== 1'b1) $display("FAIL b2b_hit: got %b want 1", pix_hit); else passes++;
   endtask

   task automatic test_reset_midstream();
      // Field still streaming from the previous task.
      pix_x = 10'(OX + 48);
      step();
      checks++; if (pix_hit !== 1'b1) $display("FAIL mid_pre_hit: got %b want 1", pix_hit); else passes++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (pix_hit !== 1'b0) $display("FAIL mid_out1_hit: got %b want 0", pix_hit); else passes++;
      checks++; if (score_bcd !== 16'h0000) $display("FAIL mid_score: got %h want 0000", score_bcd); else passes++;
      step();
      checks++; if (pix_hit !== 1'b0) $display("FAIL mid_out2_hit: got %b want 0", pix_hit); else passes++;
      step();
      checks++; if (pix_hit !== 1'b0) $display("FAIL mid_out3_hit: got %b want 0", pix_hit); else passes++;
      step();
      checks++; if (pix_hit !== 1'b1) $display("FAIL mid_resume_hit: got %b want 1", pix_hit); else passes++;
      pix_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      score_inc   = 1'b0;
      score_clr   = 1'b0;
      frame_start = 1'b0;
      pix_x       = '0;
      pix_y       = '0;
      pix_valid   = 1'b0;
      #1;
      test_reset();
      test_blank_zero();
      test_count_1234();
      test_saturate();
      test_display_copy();
      test_transparent_edges();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
